// File: rtl/hlh_pkg.sv
// hlh_pkg: shared types, default widths and the 4-state encoder for the
// hilihase change-capture block.
//   hlh_code_e  - 2-bit value code: 0, 1, X, Z
//   hlh_event_t - {id, code, ts} record at default widths
//   to_code()   - maps one 4-state bit to its hlh_code_e
package hlh_pkg;

  localparam int HLH_NUM_SIG = 8;
  localparam int HLH_DEPTH   = 16;
  localparam int HLH_TS_W    = 32;
  localparam int HLH_ID_W    = 8;
  localparam int HLH_ID_BASE = 1;

  typedef enum logic [1:0] {
    HLH_C0 = 2'd0,
    HLH_C1 = 2'd1,
    HLH_CX = 2'd2,
    HLH_CZ = 2'd3
  } hlh_code_e;

  typedef struct packed {
    logic [HLH_ID_W-1:0] id;
    hlh_code_e           code;
    logic [HLH_TS_W-1:0] ts;
  } hlh_event_t;

  // Case equality keeps X and Z distinct in simulation; a synthesised
  // netlist can only ever produce HLH_C0 or HLH_C1.
  function automatic hlh_code_e to_code(input logic v);
    if (v === 1'b0) return HLH_C0;
    if (v === 1'b1) return HLH_C1;
    if (v === 1'bz) return HLH_CZ;
    return HLH_CX;
  endfunction

endpackage

// File: rtl/hlh_evt_fifo.sv
// hlh_evt_fifo: show-ahead FIFO for packed change events.
// Ports:
//   clk, rst       clock, async active-high reset
//   push_i, din_i  write request and data (ignored when full without pop)
//   pop_i          read request (ignored when empty)
//   full_o         occupancy == DEPTH
//   empty_o        occupancy == 0
//   dout_o         head entry; holds the last head value once empty
//   level_o        occupancy
module hlh_evt_fifo
  import hlh_pkg::*;
#(
  parameter int W     = $bits(hlh_event_t),
  parameter int DEPTH = HLH_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [W-1:0]  dout_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d, cnt_pop;
  logic [W-1:0]  dout_q, dout_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // The head is registered so the payload stays put when the FIFO empties.
  // A push into an otherwise-empty FIFO bypasses the memory read.
  always_comb begin
    cnt_pop = cnt_q - LW'(do_pop);
    cnt_d   = cnt_pop + LW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    dout_d  = dout_q;
    if (cnt_d != '0) dout_d = (cnt_pop == '0) ? din_i : mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_q + AW'(do_push);
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o  = dout_q;
  assign level_o = cnt_q;

endmodule

// File: rtl/hlh_change_capture.sv
// hlh_change_capture: watches NUM_SIG 4-state signals, timestamps each code
// change and queues {id, code, time} events for the hilihase read path.
// Optional build macro HLH_INIT_SNAPSHOT_EN: on enable rising, every signal
// is queued once with its initial code (default: snapshot loads silently).
// Ports:
//   clk, rst          clock, async active-high reset
//   enable            capture enable (also gates the time counter)
//   sig_in            monitored signals
//   ev_valid/ev_ready event handshake; ev_id, ev_code, ev_time payload
//   level             FIFO occupancy
//   coalesce_cnt      saturating count of pending events overwritten
//   ovf_clr           synchronous clear of coalesce_cnt (wins over increment)
module hlh_change_capture
  import hlh_pkg::*;
#(
  parameter int NUM_SIG = HLH_NUM_SIG,
  parameter int DEPTH   = HLH_DEPTH,
  parameter int TS_W    = HLH_TS_W,
  parameter int ID_W    = HLH_ID_W,
  parameter int ID_BASE = HLH_ID_BASE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_SIG-1:0]       sig_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [ID_W-1:0]          ev_id,
  output logic [1:0]               ev_code,
  output logic [TS_W-1:0]          ev_time,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              coalesce_cnt,
  input  logic                     ovf_clr
);

  localparam int PW   = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1;
  localparam int EV_W = ID_W + 2 + TS_W;

  logic [NUM_SIG-1:0][1:0]      code_now;
  logic [NUM_SIG-1:0][1:0]      s_q, s_d, pcode_q, pcode_d;
  logic [NUM_SIG-1:0][TS_W-1:0] pts_q, pts_d;
  logic [NUM_SIG-1:0]           pend_q, pend_d;
  logic [TS_W-1:0]              ts_q;
  logic [PW-1:0]                rr_q, rr_d, gnt_idx;
  logic [15:0]                  coal_q, coal_d;
  logic [16:0]                  coal_sum;
  logic [5:0]                   coal_inc;
  logic                         en_q, en_rise, gnt_vld, fifo_full, fifo_empty, can_push;
  logic [EV_W-1:0]              push_data, head;

  always_comb begin
    code_now = '0;
    for (int i = 0; i < NUM_SIG; i++) code_now[i] = to_code(sig_in[i]);
  end

  assign en_rise  = enable && !en_q;
  assign can_push = !fifo_full || (ev_valid && ev_ready);

  // Round-robin: search starts at rr_q, the index after the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_SIG; k++) begin
      if (!gnt_vld && pend_q[(int'(rr_q) + k) % NUM_SIG]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(rr_q) + k) % NUM_SIG);
      end
    end
    gnt_vld = gnt_vld && can_push;
  end

  assign push_data = {ID_W'(ID_BASE) + ID_W'(gnt_idx), pcode_q[gnt_idx], pts_q[gnt_idx]};

  // Detection is applied after the grant so a same-cycle change re-arms the
  // pending slot with fresh data; it is only a coalesce if nothing left.
  always_comb begin
    s_d      = s_q;
    pend_d   = pend_q;
    pcode_d  = pcode_q;
    pts_d    = pts_q;
    rr_d     = rr_q;
    coal_inc = '0;
    if (gnt_vld) begin
      pend_d[gnt_idx] = 1'b0;
      rr_d = (gnt_idx == PW'(NUM_SIG - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (en_rise) begin
      s_d = code_now;
`ifdef HLH_INIT_SNAPSHOT_EN
      pend_d  = '1;
      pcode_d = code_now;
      for (int i = 0; i < NUM_SIG; i++) pts_d[i] = ts_q;
      rr_d = '0;
`endif
    end else if (enable) begin
      for (int i = 0; i < NUM_SIG; i++) begin
        if (code_now[i] != s_q[i]) begin
          s_d[i]     = code_now[i];
          pend_d[i]  = 1'b1;
          pcode_d[i] = code_now[i];
          pts_d[i]   = ts_q;
          if (pend_q[i] && !(gnt_vld && gnt_idx == PW'(i))) coal_inc = coal_inc + 6'd1;
        end
      end
    end
  end

  assign coal_sum = {1'b0, coal_q} + 17'(coal_inc);
  assign coal_d   = ovf_clr ? '0 : (coal_sum[16] ? 16'hFFFF : coal_sum[15:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      ts_q    <= '0;
      s_q     <= '0;
      pend_q  <= '0;
      pcode_q <= '0;
      pts_q   <= '0;
      rr_q    <= '0;
      coal_q  <= '0;
    end else begin
      en_q    <= enable;
      ts_q    <= enable ? ts_q + 1'b1 : ts_q;
      s_q     <= s_d;
      pend_q  <= pend_d;
      pcode_q <= pcode_d;
      pts_q   <= pts_d;
      rr_q    <= rr_d;
      coal_q  <= coal_d;
    end
  end

  hlh_evt_fifo #(.W(EV_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (gnt_vld),
    .din_i   (push_data),
    .pop_i   (ev_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (head),
    .level_o (level)
  );

  assign ev_valid                  = !fifo_empty;
  assign {ev_id, ev_code, ev_time} = head;
  assign coalesce_cnt              = coal_q;

endmodule

// File: doc/hlh_change_capture.md
Name: hlh_change_capture

Overview:
- Upstream feeder for the hilihase DPI read path.
- Watches NUM_SIG 4-state signals, detects value changes and encodes each value as a 2-bit code.
- Timestamps each change with a cycle counter and queues (id, code, time) events in a FIFO.
- Presents events on a valid/ready port; the bench-side drain loop forwards each accepted event to hilihase_read(id, code).

Parameters:
- NUM_SIG, 8: number of monitored signals (1..32).
- DEPTH, 16: event FIFO depth; power of 2, minimum 2.
- TS_W, 32: timestamp/cycle-counter width.
- ID_W, 8: event id width.
- ID_BASE, 1: id of signal index 0; signal i reports id ID_BASE+i.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable.
- sig_in  in  NUM_SIG  monitored signals, 4-state logic.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_id  out  ID_W  signal id.
- ev_code  out  2  encoded value: 0=0, 1=1, 2=X, 3=Z.
- ev_time  out  TS_W  counter value at detection.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- coalesce_cnt  out  16  changes overwritten while pending; saturates at 0xFFFF.
- ovf_clr  in  1  synchronous clear of coalesce_cnt.

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - Snapshot s_q all 0, pend all 0, FIFO empty, time counter 0, round-robin pointer 0.
- Encoding: 4-state to_code() uses case equality (===).
  - Synthesis sees only codes 0 and 1.
  - Change detection compares codes, so 0->X and X->Z both count as changes.
- Time counter:
  - Increments every clk while enable=1.
  - Frozen while enable=0.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Enable rising edge: s_q loads sig_in codes and no events are generated (unless HLH_INIT_SNAPSHOT_EN).
- Detection at edge n, while enable=1 and code(sig_in[i]) != s_q[i]:
  - s_q[i] takes the new code.
  - pend[i] set to 1; pend_code[i] takes the new code; pend_ts[i] takes the counter value at n.
  - If pend[i] is already 1: code and ts are overwritten (latest wins) and coalesce_cnt increments.
- Arbiter:
  - Round-robin over pend, starting at the index after the last grant.
  - Grants one signal per cycle, only when the FIFO is not full.
  - Grant at edge n+1 pushes {ID_BASE+i, code, ts} and clears pend[i].
  - A new change on the same signal in the same cycle wins: pend stays 1 with the new data and no coalesce increment.
- Latency: change sampled at edge n gives ev_valid=1 in the cycle after edge n+1 (FIFO empty, no contention).
- FIFO:
  - Show-ahead; ev_id, ev_code and ev_time are stable while ev_valid=1 and ev_ready=0.
  - Pop when ev_valid && ev_ready.
  - Push and pop in the same cycle are allowed when full: level unchanged, push accepted.
  - Empty: ev_valid=0 and payload holds its last value.
- Full FIFO: pending entries wait and nothing is lost at the FIFO. Losses happen only through coalescing.
- enable=0: no detection; pending entries and the FIFO keep draining.
- ovf_clr: zeroes coalesce_cnt. If an increment happens in the same cycle, clear wins.
- Reset mid-operation: all state cleared immediately, including in-flight events.

Optional Feature:
- Macro: HLH_INIT_SNAPSHOT_EN.
- Defined: on enable rising, every signal is marked pending with its current code and current counter value. This emits NUM_SIG initial-value events in round-robin order starting at index 0, mirroring hilihase_register init values.
- Undefined: the snapshot loads silently.

Decomposition:
- Package hlh_pkg:
  - hlh_code_e enum (HLH_C0=0, HLH_C1=1, HLH_CX=2, HLH_CZ=3).
  - hlh_event_t struct {id, code, time}.
  - Function to_code(logic).
  - Default width constants.
- Sub-module hlh_evt_fifo: parameterised show-ahead FIFO of hlh_event_t with level output.

Test Plan:
1. Reset, enable=1, sig_in[2] 0->1 at cycle 5 -> one event {id 3, code 1, time 5}, ev_valid two cycles later, level 1.
2. sig_in[0], [3] and [7] change in the same cycle with ev_ready=1 -> three events with ids 1, 4, 8 on consecutive cycles, all carrying the same time.
3. ev_ready=0, DEPTH=4, toggle 6 signals once -> level saturates at 4 and 2 stay pending. Raise ev_ready -> all 6 delivered, coalesce_cnt=0.
4. FIFO full, sig_in[1] goes 0->1->X across two cycles -> single id-2 event with code 2, coalesce_cnt=1. ovf_clr -> 0.
5. sig_in[4] driven 1'bz then 1'bx -> codes 3 then 2. Assert rst mid-stream -> ev_valid=0 and level=0 immediately.
6. With HLH_INIT_SNAPSHOT_EN, NUM_SIG=8, enable rises -> 8 events with ids 1..8 in order, codes matching sig_in. Without the macro -> zero events.
